timer_peripheral: RTL and testbench
===================================

Name: timer_peripheral

Overview:
- Memory-mapped peripheral slave on the data-memory bus of the single-cycle CPU.
- Contains:
  - the interval timer that produces `irq` for the control decoder (the control decoder consumes `irq`);
  - LED, switch and 7-segment registers;
  - a free-running system tick counter.
- Services the `MemRead`/`MemWrite` accesses that the control decoder issues for lw/sw to the peripheral address space.

Parameters:
- BASE_ADDR, 32'h40000000, word address of TH; all registers are at fixed offsets from it.
- LED_W, 8, width of LED register and `led` port.
- SW_W, 8, width of switch input.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- rd  input  1  bus read strobe (`MemRead`).
- wr  input  1  bus write strobe (`MemWrite`).
- addr  input  32  byte address from ALU result.
- wdata  input  32  write data (rt register value).
- rdata  output  32  read data, combinational.
- led  output  LED_W  LED register.
- switch  input  SW_W  asynchronous board switches.
- digi  output  12  7-segment register: [11:8] digit enable, [7:0] segments.
- irq  output  1  timer interrupt request, level.

Behaviour:
- Register map (offset from BASE_ADDR, word-aligned, exact 32-bit match required):
  - 0x00 TH, R/W, 32 bits: reload value.
  - 0x04 TL, R/W, 32 bits: counter.
  - 0x08 TCON, R/W, bits[2:0]:
    - [0] enable
    - [1] irq_en
    - [2] status (irq pending)
    - upper bits read as 0.
  - 0x0C LED, R/W, LED_W bits, zero-extended on read.
  - 0x10 SWITCH, read-only: synchronized switch value, zero-extended.
  - 0x14 DIGI, R/W, 12 bits.
  - 0x18 SYSTICK, read-only, 32 bits.
- Reset (reset=0, asynchronous):
  - TH, TL, TCON, LED, DIGI, SYSTICK and both switch sync stages are cleared to 0.
  - `led`=0, `digi`=0, `irq`=0.
  - `rdata` follows the read rules below; with rd=0 it is 0.
- Read path:
  - `rdata` is combinational from current register state.
  - rd=0 gives rdata=0.
  - A read of an unmapped or unaligned address gives 0.
  - No read side effects; reading TCON does not clear status.
- Write path:
  - On posedge clk with wr=1 and a mapped writable address, the register loads `wdata` (truncated to its width).
  - Writes to SWITCH, SYSTICK and unmapped addresses are ignored.
  - rd and wr both high: the read returns pre-write data and the write commits at the edge.
- Timer, per posedge when not being written:
  - TCON[0]=0: TL holds.
  - TCON[0]=1 and TL != 32'hFFFFFFFF: TL <= TL+1.
  - TCON[0]=1 and TL == 32'hFFFFFFFF: overflow.
    - TL <= TH.
    - If TCON[1]=1, TCON[2] <= 1.
    - TCON[2] stays set until software clears it.
- `irq` = TCON[1] & TCON[2], registered-state combinational; it asserts the cycle after the overflow edge.
- Collisions in one edge:
  - Software write to TL and overflow: the write wins; no reload.
  - Software write to TCON clearing status and hardware overflow setting status: set wins, so no interrupt is lost. Bits [1:0] take the written value.
  - Write to TH and overflow: TL reloads the old TH; TH takes the new value.
  - Period between interrupts = (2^32 − TH) cycles.
- SYSTICK:
  - Increments every cycle from reset release.
  - Wraps from 32'hFFFFFFFF to 0.
  - Unaffected by any bus activity.
- SWITCH: two-flop synchronizer; a change on `switch` is visible in reads 2 edges later.
- `led` and `digi` are driven directly from their registers.
- Reset assertion mid-count clears TL and TCON immediately; `irq` drops asynchronously.

Test Plan:
- Reset/defaults → hold reset=0 with the rest of the bench idle → led=0, digi=0, irq=0, and reads of TH/TL/TCON return 0; release reset, read SYSTICK after 10 cycles → 10 (±1 for read timing, documented by bench).
- Timer overflow → write TH=32'hFFFFFFFC, TL=32'hFFFFFFFC, TCON=3 → TL steps FD, FE, FF; on the 4th edge TL=FFFFFFFC and TCON=7; irq=1 the following cycle; overflow repeats every 4 cycles.
- Clear and collision → with irq=1, write TCON=3 → irq=0 next cycle; separately, time a TCON=3 write onto the overflow edge → TCON reads 7 and irq stays 1.
- TL write vs overflow → TL=32'hFFFFFFFF, enable=1, write TL=5 on that edge → TL=5 and no reload; the next edges give 6, 7.
- Peripheral I/O → write LED=8'hA5 and DIGI=12'h3F6 → led=A5, digi=3F6, read-back matches; drive switch=8'h5A → a SWITCH read returns 0x5A only after 2 edges.
- Decode → read 0x4000001C, write 0x4000000D, write SYSTICK → rdata=0 for the unmapped read; no register changes; SYSTICK keeps counting.

Source files
------------

// File: rtl/timer_peripheral.sv
// timer_peripheral
//   Memory-mapped peripheral on the CPU data bus. It holds an interval timer
//   (TH reload / TL counter / TCON control), LED and 7-segment output
//   registers, a two-flop synchronized switch input and a free-running
//   SYSTICK counter.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   rd      in   bus read strobe (MemRead)
//   wr      in   bus write strobe (MemWrite)
//   addr    in   32-bit byte address
//   wdata   in   32-bit write data
//   rdata   out  32-bit read data, combinational, 0 when rd=0 or unmapped
//   led     out  LED register
//   switch  in   asynchronous board switches
//   digi    out  7-segment register: [11:8] digit enable, [7:0] segments
//   irq     out  level interrupt = TCON.irq_en & TCON.status
module timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch,
  output logic [11:0]      digi,
  output logic             irq
);

  localparam logic [31:0] A_TH   = BASE_ADDR;
  localparam logic [31:0] A_TL   = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_TCON = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_LED  = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_SW   = BASE_ADDR + 32'h10;
  localparam logic [31:0] A_DIGI = BASE_ADDR + 32'h14;
  localparam logic [31:0] A_TICK = BASE_ADDR + 32'h18;

  logic [31:0]      r_th;
  logic [31:0]      r_tl;
  logic [2:0]       r_tcon;
  logic [LED_W-1:0] r_led;
  logic [11:0]      r_digi;
  logic [31:0]      r_systick;
  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_sync;

  logic w_we_th, w_we_tl, w_we_tcon, w_we_led, w_we_digi;
  logic w_ovf;

  // Full 32-bit compare: unaligned or out-of-range addresses match nothing.
  assign w_we_th   = wr && (addr == A_TH);
  assign w_we_tl   = wr && (addr == A_TL);
  assign w_we_tcon = wr && (addr == A_TCON);
  assign w_we_led  = wr && (addr == A_LED);
  assign w_we_digi = wr && (addr == A_DIGI);

  assign w_ovf = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);

  // TH: reload value. On a same-edge overflow TL picks up the old r_th.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_th <= '0;
    else if (w_we_th) r_th <= wdata;
  end

  // TL: a software write beats both increment and reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_tl <= '0;
    else if (w_we_tl)   r_tl <= wdata;
    else if (w_ovf)     r_tl <= r_th;
    else if (r_tcon[0]) r_tl <= r_tl + 32'd1;
  end

  // TCON: an overflow with irq_en set forces status high even while software
  // is writing TCON, so a clear racing an overflow never loses an interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcon <= '0;
    end else if (w_we_tcon) begin
      r_tcon[1:0] <= wdata[1:0];
      r_tcon[2]   <= wdata[2] | (w_ovf & r_tcon[1]);
    end else if (w_ovf && r_tcon[1]) begin
      r_tcon[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led  <= '0;
      r_digi <= '0;
    end else begin
      if (w_we_led)  r_led  <= wdata[LED_W-1:0];
      if (w_we_digi) r_digi <= wdata[11:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_systick <= '0;
    else        r_systick <= r_systick + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Read mux: pure function of current state, no side effects.
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        A_TH:    rdata = r_th;
        A_TL:    rdata = r_tl;
        A_TCON:  rdata = 32'(r_tcon);
        A_LED:   rdata = 32'(r_led);
        A_SW:    rdata = 32'(r_sw_sync);
        A_DIGI:  rdata = 32'(r_digi);
        A_TICK:  rdata = r_systick;
        default: rdata = '0;
      endcase
    end
  end

  assign led  = r_led;
  assign digi = r_digi;
  assign irq  = r_tcon[1] & r_tcon[2];

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for timer_peripheral. Inputs change at the falling edge,
// so every write commits on the following rising edge and outputs are
// sampled between edges.
module tb_timer_peripheral;

  localparam logic [31:0] B    = 32'h4000_0000;
  localparam logic [31:0] TH   = B + 32'h00;
  localparam logic [31:0] TL   = B + 32'h04;
  localparam logic [31:0] TCON = B + 32'h08;
  localparam logic [31:0] LEDA = B + 32'h0C;
  localparam logic [31:0] SWA  = B + 32'h10;
  localparam logic [31:0] DIGA = B + 32'h14;
  localparam logic [31:0] TICK = B + 32'h18;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  led, sw;
  logic [11:0] digi;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] v, s0;

  timer_peripheral #(.BASE_ADDR(B), .LED_W(8), .SW_W(8)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .led(led), .switch(sw),
    .digi(digi), .irq(irq)
  );

  always #5 clk = ~clk;

  // Call at a falling edge; the write commits on the next rising edge and
  // the task returns on the falling edge after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  // Combinational read between edges; consumes no clock edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    rd = 1'b0; addr = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; rd = 0; wr = 0; addr = '0; wdata = '0; sw = '0;
    #23;
    total++; if (led !== 8'h00) begin bad++; $display("FAIL rst_led got=%h exp=00", led); end
    total++; if (digi !== 12'h000) begin bad++; $display("FAIL rst_digi got=%h exp=000", digi); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    bus_read(TH, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_th got=%h exp=0", v); end
    bus_read(TL, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_tl got=%h exp=0", v); end
    bus_read(TCON, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_tcon got=%h exp=0", v); end
    @(negedge clk);
    reset = 1'b1;
    // Released on a falling edge: exactly 10 rising edges by the 10th fall.
    repeat (10) tick();
    bus_read(TICK, v);
    total++; if (v !== 32'd10) begin bad++; $display("FAIL systick10 got=%0d exp=10", v); end
  endtask

  task automatic test_overflow();
    bus_write(TH, 32'hFFFF_FFFC);
    bus_write(TL, 32'hFFFF_FFFC);
    bus_write(TCON, 32'h3);
    bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFC) begin bad++; $display("FAIL ovf_tl0 got=%h exp=fffffffc", v); end
    tick(); bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFD) begin bad++; $display("FAIL ovf_fd got=%h exp=fffffffd", v); end
    tick(); bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ovf_fe got=%h exp=fffffffe", v); end
    tick(); bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ovf_ff got=%h exp=ffffffff", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovf_irq_pre got=%b exp=0", irq); end
    tick(); bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFC) begin bad++; $display("FAIL ovf_reload got=%h exp=fffffffc", v); end
    bus_read(TCON, v);
    total++; if (v !== 32'h7) begin bad++; $display("FAIL ovf_tcon got=%h exp=7", v); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovf_irq got=%b exp=1", irq); end
    repeat (3) tick();
    bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ovf2_ff got=%h exp=ffffffff", v); end
    tick(); bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFC) begin bad++; $display("FAIL ovf2_reload got=%h exp=fffffffc", v); end
    // Reading TCON must not have cleared status.
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovf2_irq got=%b exp=1", irq); end
  endtask

  task automatic test_clear_collision();
    // TL=FC here: the clear edge has no overflow.
    bus_write(TCON, 32'h3);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clr_irq got=%b exp=0", irq); end
    bus_read(TCON, v);
    total++; if (v !== 32'h3) begin bad++; $display("FAIL clr_tcon got=%h exp=3", v); end
    tick(); tick();
    bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL col_pre got=%h exp=ffffffff", v); end
    bus_write(TCON, 32'h3);  // lands on the overflow edge
    bus_read(TCON, v);
    total++; if (v !== 32'h7) begin bad++; $display("FAIL col_tcon got=%h exp=7", v); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL col_irq got=%b exp=1", irq); end
  endtask

  task automatic test_tl_write_vs_ovf();
    bus_write(TCON, 32'h0);
    bus_write(TL, 32'hFFFF_FFFF);
    bus_write(TCON, 32'h1);
    bus_write(TL, 32'h5);    // overflow edge, write wins
    bus_read(TL, v);
    total++; if (v !== 32'h5) begin bad++; $display("FAIL tlw_5 got=%h exp=5", v); end
    tick(); bus_read(TL, v);
    total++; if (v !== 32'h6) begin bad++; $display("FAIL tlw_6 got=%h exp=6", v); end
    tick(); bus_read(TL, v);
    total++; if (v !== 32'h7) begin bad++; $display("FAIL tlw_7 got=%h exp=7", v); end
  endtask

  task automatic test_th_write_vs_ovf();
    bus_write(TCON, 32'h0);
    bus_write(TL, 32'hFFFF_FFFF);
    bus_write(TCON, 32'h1);  // enable only, irq_en=0
    bus_write(TH, 32'h10);   // overflow edge: reload uses old TH
    bus_read(TL, v);
    total++; if (v !== 32'hFFFF_FFFC) begin bad++; $display("FAIL thw_tl got=%h exp=fffffffc", v); end
    bus_read(TH, v);
    total++; if (v !== 32'h10) begin bad++; $display("FAIL thw_th got=%h exp=10", v); end
    bus_read(TCON, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL thw_nostat got=%h exp=1", v); end
    bus_write(TCON, 32'h0);
  endtask

  task automatic test_io();
    bus_write(LEDA, 32'h1234_56A5);
    bus_write(DIGA, 32'hABCD_13F6);
    total++; if (led !== 8'hA5) begin bad++; $display("FAIL io_led got=%h exp=a5", led); end
    total++; if (digi !== 12'h3F6) begin bad++; $display("FAIL io_digi got=%h exp=3f6", digi); end
    bus_read(LEDA, v);
    total++; if (v !== 32'hA5) begin bad++; $display("FAIL io_led_rd got=%h exp=a5", v); end
    bus_read(DIGA, v);
    total++; if (v !== 32'h3F6) begin bad++; $display("FAIL io_digi_rd got=%h exp=3f6", v); end
    sw = 8'h5A;
    bus_read(SWA, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL sw_0 got=%h exp=0", v); end
    tick(); bus_read(SWA, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL sw_1 got=%h exp=0", v); end
    tick(); bus_read(SWA, v);
    total++; if (v !== 32'h5A) begin bad++; $display("FAIL sw_2 got=%h exp=5a", v); end
  endtask

  task automatic test_decode();
    bus_read(B + 32'h1C, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL dec_unmapped got=%h exp=0", v); end
    bus_read(B + 32'h01, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL dec_unaligned got=%h exp=0", v); end
    addr = TH; rd = 1'b0; #1 v = rdata; addr = '0;
    total++; if (v !== 32'h0) begin bad++; $display("FAIL dec_rd0 got=%h exp=0", v); end
    bus_write(B + 32'h0D, 32'hFF);
    total++; if (led !== 8'hA5) begin bad++; $display("FAIL dec_led_port got=%h exp=a5", led); end
    bus_read(LEDA, v);
    total++; if (v !== 32'hA5) begin bad++; $display("FAIL dec_led got=%h exp=a5", v); end
    bus_write(SWA, 32'h0);
    bus_read(SWA, v);
    total++; if (v !== 32'h5A) begin bad++; $display("FAIL dec_sw got=%h exp=5a", v); end
    bus_read(TICK, s0);
    bus_write(TICK, 32'h0);
    bus_read(TICK, v);
    total++; if (v !== s0 + 32'd1) begin bad++; $display("FAIL dec_tick got=%h exp=%h", v, s0 + 32'd1); end
  endtask

  task automatic test_rd_wr_same();
    rd = 1'b1; wr = 1'b1; addr = LEDA; wdata = 32'h3C;
    #1 v = rdata;
    total++; if (v !== 32'hA5) begin bad++; $display("FAIL rw_pre got=%h exp=a5", v); end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    bus_read(LEDA, v);
    total++; if (v !== 32'h3C) begin bad++; $display("FAIL rw_post got=%h exp=3c", v); end
  endtask

  task automatic test_async_reset();
    bus_write(TCON, 32'h0);
    bus_write(TL, 32'hFFFF_FFFE);
    bus_write(TCON, 32'h3);  // TCON was 0 on this edge, TL holds FE
    tick(); tick();          // FF, then overflow -> TL=TH=0x10
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ar_irq_pre got=%b exp=1", irq); end
    #2 reset = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ar_irq got=%b exp=0", irq); end
    total++; if (led !== 8'h00) begin bad++; $display("FAIL ar_led got=%h exp=00", led); end
    bus_read(TL, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL ar_tl got=%h exp=0", v); end
    bus_read(TCON, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL ar_tcon got=%h exp=0", v); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overflow();
    test_clear_collision();
    test_tl_write_vs_ovf();
    test_th_write_vs_ovf();
    test_io();
    test_decode();
    test_rd_wr_same();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
